// File: rtl/aes_encrypt_seq_pkg.sv
// Shared AES primitives: S-box table, GF(2^8) arithmetic, key-schedule helpers, FSM encoding.
// Latency: none; everything here is combinational.
// Backpressure: not applicable.
package aes_encrypt_seq_pkg;

   // Legal key-length / round-count pairs.
   localparam int nkAes128 = 4;
   localparam int nrAes128 = 10;
   localparam int nkAes192 = 6;
   localparam int nrAes192 = 12;
   localparam int nkAes256 = 8;
   localparam int nrAes256 = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } aesState_t;

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] sboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return sboxTable[2047 - 8*int'(b) -: 8];
   endfunction

   // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product by shift-and-add.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rotWord(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Round constant for schedule iteration n (n >= 1): x^(n-1).
   function automatic logic [7:0] rcon(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 1; k < n; k++) r = xtime(r);
      return r;
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on lastRound), AddRoundKey.
// Latency: zero cycles (combinational).
// Backpressure: none; the caller registers the result.
module aes_enc_round
   import aes_encrypt_seq_pkg::*;
(
   input  logic [127:0] stateIn,
   input  logic [127:0] roundKey,
   input  logic         lastRound,
   output logic [127:0] stateOut
);

   // Byte i is row i%4, column i/4; byte 0 sits in the top bits.
   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];
   logic [7:0] a0, a1, a2, a3;

   // Full round datapath, with MixColumns bypassed for the final round.
   always_comb begin
      stateOut = '0;
      a0 = 8'h0;
      a1 = 8'h0;
      a2 = 8'h0;
      a3 = 8'h0;
      for (int i = 0; i < 16; i++) begin
         sb[i] = sbox(stateIn[127-8*i -: 8]);
         sr[i] = 8'h0;
         mc[i] = 8'h0;
      end
      // Row r rotates left by r columns.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      for (int i = 0; i < 16; i++)
         stateOut[127-8*i -: 8] = (lastRound ? sr[i] : mc[i]) ^ roundKey[127-8*i -: 8];
   end

endmodule

// File: rtl/aes_key_expand.sv
// Combinational AES key expansion; round key r lands in schedule[128*r +: 128].
// Latency: zero cycles (pure combinational from key).
// Backpressure: none; output follows key continuously.
module aes_key_expand
   import aes_encrypt_seq_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic [Nk*32-1:0]      key,
   output logic [128*(Nr+1)-1:0] schedule
);

   localparam int numWords = 4 * (Nr + 1);

   logic [31:0] w [numWords];
   logic [31:0] temp;

   // Word recurrence; word 0 is the most significant key word.
   always_comb begin
      temp = 32'h0;
      for (int i = 0; i < numWords; i++) w[i] = 32'h0;
      for (int i = 0; i < Nk; i++) w[i] = key[32*(Nk-1-i) +: 32];
      for (int i = Nk; i < numWords; i++) begin
         temp = w[i-1];
         if (i % Nk == 0)
            temp = subWord(rotWord(temp)) ^ {rcon(i / Nk), 24'h0};
         else if (Nk > 6 && i % Nk == 4)
            temp = subWord(temp);
         w[i] = w[i-Nk] ^ temp;
      end
   end

   // Pack four words per round key, first word in the top 32 bits.
   always_comb begin
      schedule = '0;
      for (int r = 0; r <= Nr; r++)
         schedule[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   end

endmodule

// File: rtl/aes_encrypt_seq.sv
// Iterative AES encryptor: one round per cycle through a single shared round datapath.
// Latency: out_valid rises Nr cycles after the accepting edge.
// Backpressure: result and out_valid hold in DONE until out_ready; in_ready low while busy.
module aes_encrypt_seq
   import aes_encrypt_seq_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      data_in,
   input  logic [Nk*32-1:0]  key_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      data_encrypted,
   output logic              busy
);

   localparam logic [3:0] lastCnt = 4'(Nr);

   aesState_t             fsm;
   logic [127:0]          stateReg;
   logic [Nk*32-1:0]      keyReg;
   logic [3:0]            roundCnt;
   logic [128*(Nr+1)-1:0] schedule;
   logic [127:0]          roundKey;
   logic [127:0]          roundOut;
   logic                  lastRound;

   // The schedule is derived from the latched key so input key changes cannot disturb a block.
   aes_key_expand #(.Nk(Nk), .Nr(Nr)) uKeyExpand (
      .key      (keyReg),
      .schedule (schedule)
   );

   assign roundKey  = schedule[128*roundCnt +: 128];
   assign lastRound = (roundCnt == lastCnt);

   aes_enc_round uRound (
      .stateIn   (stateReg),
      .roundKey  (roundKey),
      .lastRound (lastRound),
      .stateOut  (roundOut)
   );

   assign data_encrypted = stateReg;

   // Control FSM with registered handshake outputs; in_ready only rises once out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         stateReg  <= '0;
         keyReg    <= '0;
         roundCnt  <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid && in_ready) begin
                  keyReg   <= key_in;
                  // Round key 0 is the first four key words, taken straight from the input.
                  stateReg <= data_in ^ key_in[Nk*32-1 -: 128];
                  roundCnt <= 4'd1;
                  fsm      <= ROUND;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ROUND: begin
               stateReg <= roundOut;
               if (lastRound) begin
                  fsm       <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  roundCnt <= roundCnt + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm       <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               fsm       <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule
